// File: rtl/program_seq_pkg.sv
// Shared types and default sizing for the program sequencer and its memory.
package program_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  localparam int SEQ_W     = 10;
  localparam int SEQ_DEPTH = 16;

endpackage

// File: rtl/prog_mem.sv
// Program store: synchronous write, combinational read so the sequencer can
// load the next word onto its output register on the same edge it advances.
module prog_mem
  import program_seq_pkg::*;
#(
  parameter int W     = SEQ_W,
  parameter int DEPTH = SEQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Append path; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Stored-program word source for the bus processor: loads a program in IDLE,
// then replays it word by word as the processor consumes each one.
module program_sequencer
  import program_seq_pkg::*;
#(
  parameter int W     = SEQ_W,
  parameter int DEPTH = SEQ_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [W-1:0]             WR_DATA,
  input  logic                     CLR_PROG,
  input  logic                     START,
  input  logic                     STOP,
  input  logic                     LOOP,
  input  logic                     TAKE,
  output logic [W-1:0]             DOUT,
  output logic                     VALID,
  output logic [$clog2(DEPTH)-1:0] PC,
  output logic [$clog2(DEPTH):0]   LEN,
  output logic                     FULL,
  output logic                     BUSY,
  output logic                     HALTED
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  seq_state_t    state_r;
  logic [AW-1:0] pc_r;
  logic [LW-1:0] len_r;
  logic [W-1:0]  dout_r;
  logic          valid_r;
  logic          full_r;
  logic          busy_r;
  logic          halted_r;

  logic          take_ok_s;
  logic          at_last_s;
  logic          mem_we_s;
  logic [AW-1:0] rd_addr_s;
  logic [W-1:0]  rd_data_s;

  // Decode this cycle's actions in priority order and pick the word to load.
  always_comb begin
    take_ok_s = TAKE && valid_r && (state_r == RUN);
    at_last_s = ({1'b0, pc_r} == (len_r - LW'(1)));
    mem_we_s  = (state_r == IDLE) && WR_EN && !full_r &&
                !STOP && !START && !CLR_PROG;
    if (START || at_last_s) begin
      rd_addr_s = AW'(0);
    end else begin
      rd_addr_s = pc_r + AW'(1);
    end
  end

  prog_mem #(
    .W    (W),
    .DEPTH(DEPTH)
  ) u_prog_mem (
    .clk  (CLK),
    .we   (mem_we_s),
    .waddr(len_r[AW-1:0]),
    .wdata(WR_DATA),
    .raddr(rd_addr_s),
    .rdata(rd_data_s)
  );

  // Sequencer FSM with counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= IDLE;
      pc_r     <= AW'(0);
      len_r    <= LW'(0);
      dout_r   <= W'(0);
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else if (STOP) begin
      state_r  <= IDLE;
      pc_r     <= AW'(0);
      dout_r   <= W'(0);
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else if (START) begin
      // An empty program cannot be started; RUN/HALT always hold a program.
      if (len_r != LW'(0)) begin
        state_r  <= RUN;
        pc_r     <= AW'(0);
        dout_r   <= rd_data_s;
        valid_r  <= 1'b1;
        busy_r   <= 1'b1;
        halted_r <= 1'b0;
      end
    end else if (take_ok_s) begin
      if (!at_last_s || LOOP) begin
        pc_r   <= rd_addr_s;
        dout_r <= rd_data_s;
      end else begin
        state_r  <= HALT;
        dout_r   <= W'(0);
        valid_r  <= 1'b0;
        busy_r   <= 1'b0;
        halted_r <= 1'b1;
      end
    end else if ((state_r == IDLE) && CLR_PROG) begin
      len_r  <= LW'(0);
      full_r <= 1'b0;
    end else if (mem_we_s) begin
      len_r  <= len_r + LW'(1);
      full_r <= ((len_r + LW'(1)) == LW'(DEPTH));
    end
  end

  assign DOUT   = dout_r;
  assign VALID  = valid_r;
  assign PC     = pc_r;
  assign LEN    = len_r;
  assign FULL   = full_r;
  assign BUSY   = busy_r;
  assign HALTED = halted_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: load, replay, loop, stop, full and
// asynchronous reset behaviour against hand-computed values.
module tb_program_sequencer;

  localparam int W     = 10;
  localparam int DEPTH = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         WR_EN;
  logic [W-1:0] WR_DATA;
  logic         CLR_PROG;
  logic         START;
  logic         STOP;
  logic         LOOP;
  logic         TAKE;
  logic [W-1:0] DOUT;
  logic         VALID;
  logic [3:0]   PC;
  logic [4:0]   LEN;
  logic         FULL;
  logic         BUSY;
  logic         HALTED;

  int tests_run = 0;
  int tests_failed = 0;

  program_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .CLR_PROG(CLR_PROG), .START(START), .STOP(STOP), .LOOP(LOOP),
    .TAKE(TAKE), .DOUT(DOUT), .VALID(VALID), .PC(PC), .LEN(LEN),
    .FULL(FULL), .BUSY(BUSY), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    WR_EN = 1'b1;
    WR_DATA = d;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  logic [W-1:0] loop_dout [5] = '{10'h202, 10'h303, 10'h101, 10'h202, 10'h303};
  logic [3:0]   loop_pc   [5] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2};

  initial begin
    RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; CLR_PROG = 1'b0;
    START = 1'b0; STOP = 1'b0; LOOP = 1'b0; TAKE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    check("rst_dout", DOUT, 0);
    check("rst_valid", VALID, 0);
    check("rst_pc", PC, 0);
    check("rst_len", LEN, 0);
    check("rst_full", FULL, 0);
    check("rst_busy", BUSY, 0);
    check("rst_halted", HALTED, 0);

    write_word(10'h101);
    write_word(10'h202);
    write_word(10'h303);
    check("load_len", LEN, 3);

    // Single-shot replay
    pulse_start();
    check("start_valid", VALID, 1);
    check("start_dout", DOUT, 10'h101);
    check("start_busy", BUSY, 1);
    TAKE = 1'b1;
    tick();
    check("take1_dout", DOUT, 10'h202);
    check("take1_pc", PC, 1);
    tick();
    check("take2_dout", DOUT, 10'h303);
    check("take2_pc", PC, 2);
    tick();
    check("halt_valid", VALID, 0);
    check("halt_flag", HALTED, 1);
    check("halt_dout", DOUT, 0);
    check("halt_pc", PC, 2);
    check("halt_busy", BUSY, 0);
    check("halt_len", LEN, 3);
    tick();
    TAKE = 1'b0;
    check("halt_take_pc", PC, 2);
    check("halt_take_flag", HALTED, 1);

    // Looping replay
    LOOP = 1'b1;
    pulse_start();
    check("loop_start_dout", DOUT, 10'h101);
    check("loop_start_halted", HALTED, 0);
    TAKE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("loop_dout", DOUT, loop_dout[i]);
      check("loop_pc", PC, loop_pc[i]);
      check("loop_halted", HALTED, 0);
    end
    TAKE = 1'b0;

    // Writes and clears are ignored while running
    WR_EN = 1'b1; WR_DATA = 10'h3ff;
    tick();
    WR_EN = 1'b0;
    check("run_wr_len", LEN, 3);
    CLR_PROG = 1'b1;
    tick();
    CLR_PROG = 1'b0;
    check("run_clr_len", LEN, 3);
    check("run_clr_dout", DOUT, 10'h303);

    // Restart mid-run, advance to PC=1, then STOP wins over TAKE
    pulse_start();
    check("restart_pc", PC, 0);
    check("restart_dout", DOUT, 10'h101);
    TAKE = 1'b1;
    tick();
    check("pre_stop_pc", PC, 1);
    STOP = 1'b1;
    tick();
    STOP = 1'b0; TAKE = 1'b0;
    check("stop_busy", BUSY, 0);
    check("stop_pc", PC, 0);
    check("stop_valid", VALID, 0);
    check("stop_dout", DOUT, 0);
    check("stop_len", LEN, 3);
    pulse_start();
    check("replay_dout", DOUT, 10'h101);
    check("replay_valid", VALID, 1);

    // Asynchronous reset between edges
    TAKE = 1'b1;
    tick();
    TAKE = 1'b0;
    check("pre_rst_pc", PC, 1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_dout", DOUT, 0);
    check("arst_valid", VALID, 0);
    check("arst_pc", PC, 0);
    check("arst_len", LEN, 0);
    check("arst_busy", BUSY, 0);
    #1;
    RST = 1'b0;
    tick();

    // START with an empty program is ignored
    pulse_start();
    check("empty_start_valid", VALID, 0);
    check("empty_start_busy", BUSY, 0);

    // Fill to capacity, then one extra write
    LOOP = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      write_word(W'(10'h040 + i));
      if (i == DEPTH - 2) check("full_early", FULL, 0);
    end
    check("full_set", FULL, 1);
    check("full_len", LEN, 16);
    write_word(10'h3aa);
    check("full_len_hold", LEN, 16);
    pulse_start();
    check("full_mem0", DOUT, 10'h040);
    TAKE = 1'b1;
    tick();
    TAKE = 1'b0;
    check("full_mem1", DOUT, 10'h041);

    // Clear in IDLE drops the program
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    CLR_PROG = 1'b1;
    tick();
    CLR_PROG = 1'b0;
    check("clr_len", LEN, 0);
    check("clr_full", FULL, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
